// File: rtl/pipeline_stage_slots.sv
// pipeline_stage_slots
//   Elastic pipeline register carrying SLOTS parallel issue slots (data +
//   control per slot) under one valid/ready handshake. Optional skid entry,
//   flush, NOP-bubble insertion and per-slot control kill on load.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   upstream entry present
//   in_ready   stage can accept an entry this cycle
//   in_data    slot i at [i*DATA_W +: DATA_W]
//   in_ctrl    slot i at [i*CTRL_W +: CTRL_W]
//   slot_kill  per-slot zeroing of control on load
//   flush      discard all held and incoming entries
//   bubble     insert a NOP entry and block upstream
//   out_valid  output entry present
//   out_ready  downstream accepts the entry
//   out_data   registered data
//   out_ctrl   registered control
//   occupancy  number of held entries (0..2)
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing held, main invalid
// ST_FULL  | main entry valid, skid invalid
// ST_SKID  | main and skid valid, upstream blocked (SKID=1)
module pipeline_stage_slots #(
  parameter int SLOTS  = 2,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLOTS*DATA_W-1:0] in_data,
  input  logic [SLOTS*CTRL_W-1:0] in_ctrl,
  input  logic [SLOTS-1:0]        slot_kill,
  input  logic                    flush,
  input  logic                    bubble,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SLOTS*DATA_W-1:0] out_data,
  output logic [SLOTS*CTRL_W-1:0] out_ctrl,
  output logic [1:0]              occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SLOTS*DATA_W-1:0] main_data_q, main_data_d;
  logic [SLOTS*CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [SLOTS*DATA_W-1:0] skid_data_q, skid_data_d;
  logic [SLOTS*CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic                    rdy_q, rdy_d;
  logic [SLOTS*CTRL_W-1:0] load_ctrl;
  logic                    main_valid;
  logic                    skid_valid;
  logic                    in_fire;
  logic                    out_fire;

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_SKID);

  // rdy_q resets low so in_ready stays low through reset and rises at the
  // first edge afterwards.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = rdy_q & ~bubble;
    end else begin : g_noskid
      assign in_ready = rdy_q & ~bubble & (~main_valid | out_ready);
    end
  endgenerate

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;

  always_comb begin
    case (state_q)
      ST_FULL: occupancy = 2'd1;
      ST_SKID: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    load_ctrl = in_ctrl;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_kill[i]) load_ctrl[i*CTRL_W +: CTRL_W] = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Data fields keep their last value; only control is cleared.
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else if (bubble) begin
      // NOP goes into main only if main is free this cycle; skid is left alone.
      if (!main_valid || out_fire) begin
        main_ctrl_d = '0;
        state_d     = skid_valid ? ST_SKID : ST_FULL;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_data_d = in_data;
            main_ctrl_d = load_ctrl;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          // With SKID=0, in_fire implies out_fire, so ST_SKID is unreachable.
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = load_ctrl;
          end else if (in_fire) begin
            skid_data_d = in_data;
            skid_ctrl_d = load_ctrl;
            state_d     = ST_SKID;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    rdy_d = (SKID == 0) ? 1'b1 : (state_d != ST_SKID);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: doc/pipeline_stage_slots.md
Name: pipeline_stage_slots

Overview:
- Parametrised, elastic pipeline register for the VLIW datapath; one instance replaces a hand-built IF/ID, ID/EX, EX/MEM or MEM/WB stage.
- Carries SLOTS parallel issue slots, each with a data field and a control field, under a single valid/ready handshake.
- Adds an optional skid buffer, a priority-ordered flush, NOP-bubble insertion and per-slot control kill.
- Flush and bubble clear control fields only; data fields are never cleared except by reset.

Parameters:
- SLOTS, 2, number of parallel issue slots (1..4).
- DATA_W, 32, data bits per slot.
- CTRL_W, 8, control bits per slot. All-zero control means NOP.
- SKID, 1: 1 = two-entry stage (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  SLOTS*DATA_W  slot i occupies bits [i*DATA_W +: DATA_W].
- in_ctrl  in  SLOTS*CTRL_W  slot i occupies bits [i*CTRL_W +: CTRL_W].
- slot_kill  in  SLOTS  per-slot zeroing of control on load.
- flush  in  1  synchronous discard of all held and incoming entries.
- bubble  in  1  insert a NOP entry and block upstream.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts the entry.
- out_data  out  SLOTS*DATA_W  registered data.
- out_ctrl  out  SLOTS*CTRL_W  registered control.
- occupancy  out  2  number of entries held (0..2).

Behaviour:
- Reset (reset=0, asynchronous) clears all internal registers:
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid entry invalid.
  - in_ready=0 while reset is low; in_ready=1 in the first cycle after reset rises.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready at the clock edge.
  - Output transfer occurs when out_valid & out_ready at the clock edge.
  - out_valid/out_data/out_ctrl hold stable while out_valid & !out_ready.
- Latency: 1 cycle from input transfer to out_valid in the EMPTY state; no combinational path from in_* to out_*.
- Load rule: an entry is loaded with ctrl slot i forced to 0 when slot_kill[i]=1. slot_kill is sampled on the same cycle as the load.
- States (SKID=1):
  - EMPTY: occupancy=0, in_ready=1. On input transfer -> FULL.
  - FULL: occupancy=1, in_ready=1.
    - Input transfer and output transfer in the same cycle: main is replaced; stay FULL.
    - Input transfer only: incoming entry goes to skid -> SKID.
    - Output transfer only -> EMPTY.
  - SKID: occupancy=2, in_ready=0. On output transfer, skid moves to main -> FULL.
  - in_ready is a registered signal: 1 exactly when the skid entry is invalid.
- SKID=0:
  - Only EMPTY and FULL exist; occupancy never exceeds 1.
  - in_ready = !out_valid | out_ready (combinational).
- Priority order: reset > flush > bubble > normal.
- flush=1:
  - Next cycle: out_valid=0, out_ctrl=0, skid invalid, occupancy=0, in_ready=1.
  - An input transferred in the flush cycle is discarded.
  - out_data retains its last value.
  - flush overrides a simultaneous output stall.
- bubble=1 (and flush=0):
  - in_ready is forced to 0 combinationally in the bubble cycle, overriding the registered value; no input transfer can occur.
  - If main is empty or draining that cycle, main loads a NOP: valid=1, ctrl=0, data unchanged.
  - Otherwise main holds its entry and the bubble is retried on the next cycle.
  - Bubble never touches the skid entry.
  - A bubble held high for N free cycles produces N consecutive NOP entries.
- occupancy = number of valid entries among main and skid, updated at the same edge as those entries.
- Reset asserted mid-transfer takes effect immediately; no partial entry survives.

Test Plan:
- Reset then stream: hold reset low for 3 cycles, release, drive 4 entries with in_ctrl=0x11,0x22,0x33,0x44 and out_ready=1 -> out_ctrl matches each value 1 cycle after its transfer; occupancy stays 1; in_ready stays 1.
- Backpressure (SKID=1): out_ready=0, send 0xA1 then 0xA2 -> occupancy=2 and in_ready=0 after the 2nd edge. Raise out_ready -> 0xA1 then 0xA2 output in order, no loss or duplication.
- Flush with stage full: occupancy=2, assert flush together with in_valid=1 carrying 0xB3 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, out_data unchanged; 0xB3 never appears at the output.
- Bubble: hold bubble=1 for 2 cycles with stage EMPTY and out_ready=1 -> two outputs with out_valid=1 and out_ctrl=0; in_ready=0 in both cycles; the upstream entry is accepted the cycle after bubble drops.
- Slot kill: SLOTS=2, in_ctrl={0x5A,0xC3}, slot_kill=2'b01 -> out_ctrl={0x5A,0x00}; both data fields pass unmodified.
- SKID=0 build: out_ready toggling 1,0,1 -> in_ready follows !out_valid|out_ready in the same cycle; occupancy never exceeds 1.
